sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
Shares the single SDRAM controller command port (az_*/za_*) between two requesters. Port 0 is the CPU northbridge RAM path; port 1 is a secondary bus master (DMA or video fetch). Port 0 has fixed priority, with a starvation limit that guarantees port 1 service. Read returns are in order from the controller and are steered back to the issuing port through a tag FIFO.

Parameters:
ADDR_W, 22, word address width (byte address bits [22:1]).
DATA_W, 16, data width.
TAG_DEPTH, 4, maximum outstanding reads; power of two, 2..16.
STARVE_LIMIT, 8, consecutive port-0 accepts allowed while port 1 waits; range 1..255.

Ports:
clk  in  1  system clock (2x CPU clock domain)
reset_n  in  1  asynchronous active-low reset
m0_addr  in  ADDR_W  port 0 word address
m0_be_n  in  2  port 0 byte enables, active low
m0_wdata  in  DATA_W  port 0 write data
m0_rd_n  in  1  port 0 read strobe, active low
m0_wr_n  in  1  port 0 write strobe, active low
m0_waitrequest  out  1  port 0 stall; command accepted on a clk edge where strobe low and this is 0
m0_rdata  out  DATA_W  port 0 read data (za_data pass-through)
m0_valid  out  1  port 0 read data valid
m1_*  (same nine signals as m0_* for port 1)
az_addr  out  ADDR_W  to SDRAM controller
az_be_n  out  2  to SDRAM controller
az_data  out  DATA_W  to SDRAM controller
az_rd_n  out  1  to SDRAM controller
az_wr_n  out  1  to SDRAM controller
za_data  in  DATA_W  read data from controller
za_valid  in  1  read data valid from controller
za_waitrequest  in  1  controller stall
arb_sel  out  1  currently granted port (debug)
tag_count  out  $clog2(TAG_DEPTH+1)  outstanding reads
err_unexp_valid  out  1  sticky: za_valid seen with tag FIFO empty

Behaviour:
- Request: reqN = ~mN_rd_n | ~mN_wr_n. If both strobes are low, the write wins and the read is ignored for that beat.
- Reset (reset_n low, any time): tag FIFO empty, tag_count=0, starve counter=0, lock=0, arb_sel=0, err_unexp_valid=0. While reset is low, force az_rd_n=az_wr_n=1, m0/m1_waitrequest=1, m0/m1_valid=0. Outstanding reads are discarded; late za_valid after reset sets err_unexp_valid.
- Selection (combinational from registered state):
  - lock=1: sel = arb_sel (held).
  - Otherwise, if req1 and (~req0 or starve==STARVE_LIMIT): sel=1.
  - Otherwise, if req0: sel=0.
  - Otherwise: sel = arb_sel.
  - arb_sel <= sel every clk.
- Mux: az_addr/az_be_n/az_data = selected port's signals.
  - az_wr_n = ~(req_sel & write_sel).
  - az_rd_n = ~(req_sel & read_sel & ~tag_full).
  - A read while the tag FIFO is full is not presented to the controller.
- Stall: mN_waitrequest = 1 unless (sel==N & reqN & ~za_waitrequest & ~(read beat & tag_full)). The unselected port always sees 1.
- Accept = presented command (az_rd_n or az_wr_n low) & ~za_waitrequest, sampled at the clk edge.
- Lock: lock <= presented command & za_waitrequest. Address and strobes stay on the same port until accepted; no regrant mid-stall.
- Starve counter:
  - Port-0 accept while req1 high: increment, saturating at STARVE_LIMIT.
  - Port-1 accept, or req1 low: clear to 0.
- Tag FIFO: TAG_DEPTH x 1 bit, head/tail pointers, count register.
  - Push sel on an accepted read. Pop on za_valid when not empty.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo TAG_DEPTH.
  - tag_full = (count==TAG_DEPTH); a pop in the same cycle does not unblock the read until the next cycle.
- Return path (zero latency, combinational):
  - m0_rdata = m1_rdata = za_data.
  - mN_valid = za_valid & ~empty & (head==N).
  - za_valid with empty FIFO: no valid to either port; err_unexp_valid <= 1, cleared only by reset.
- Writes never enter the FIFO. A write can be accepted while reads are outstanding or the FIFO is full.
- Throughput: one command per clk when za_waitrequest is low; arbitration adds no cycles.

Test Plan:
- Port-0 read only, addr 22'h000123, za_waitrequest=0; controller returns 16'hBEEF 3 clks later -> az_rd_n low 1 clk, m0_waitrequest=0 that clk, m0_valid=1 with m0_rdata=16'hBEEF, m1_valid=0, tag_count 1 then 0.
- Both ports hold continuous reads, STARVE_LIMIT=8, no controller stall -> accept sequence is 8x port 0, 1x port 1, repeating; starve counter returns to 0 after each port-1 accept.
- Port-1 write asserted, za_waitrequest held high 5 clks, port 0 requests on clk 2 -> az_addr/az_data stay port-1 values and arb_sel=1 for all 5 clks; port-1 write accepted on clk 6, port 0 granted clk 7.
- Issue 4 reads (alternating ports) with no za_valid, then a 5th read -> 5th not presented (az_rd_n=1, requester waitrequest=1); a port write is still accepted; the 5th read is accepted 1 clk after the first za_valid pop; returns routed in issue order 0,1,0,1.
- Push and za_valid pop on the same clk at count=2 -> count stays 2, correct port receives valid; pointers wrap past index 3 without error.
- Assert reset_n low with 3 reads outstanding, release, then drive za_valid -> tag_count=0, no mN_valid, err_unexp_valid=1.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_port_arbiter_if : Avalon-style SDRAM command/return bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic [1:0]        be_n;
  logic [DATA_W-1:0] wdata;
  logic              rd_n;
  logic              wr_n;
  logic              waitrequest;
  logic [DATA_W-1:0] rdata;
  logic              valid;

  // master issues commands and receives stall/returns; slave is the opposite side
  modport master (
    output addr, be_n, wdata, rd_n, wr_n,
    input  waitrequest, rdata, valid
  );
  modport slave (
    input  addr, be_n, wdata, rd_n, wr_n,
    output waitrequest, rdata, valid
  );
endinterface
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_port_arbiter : two-port fixed-priority SDRAM command arbiter with
//                      starvation limit and in-order read tag FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter int ADDR_W       = 22,
  parameter int DATA_W       = 16,
  parameter int TAG_DEPTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  sdram_port_arbiter_if.slave              m0,
  sdram_port_arbiter_if.slave              m1,
  sdram_port_arbiter_if.master             az,
  output logic                             arb_sel,
  output logic [$clog2(TAG_DEPTH+1)-1:0]   tag_count,
  output logic                             err_unexp_valid
);

  localparam int             CW         = $clog2(TAG_DEPTH + 1);
  localparam int             PW         = $clog2(TAG_DEPTH);
  localparam logic [CW-1:0]  C_FULL     = CW'(TAG_DEPTH);
  localparam logic [7:0]     C_STARVE   = 8'(STARVE_LIMIT);

  logic                  r_arb_sel;
  logic                  r_lock;
  logic [7:0]            r_starve;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [TAG_DEPTH-1:0]  r_tags;

  logic w_req0, w_req1, w_rd0, w_rd1, w_wr0, w_wr1;
  logic w_sel, w_req_s, w_rd_s, w_wr_s;
  logic w_full, w_empty;
  logic w_present_rd, w_present_wr, w_grant_ok;
  logic w_accept, w_push, w_pop, w_head_tag;

  // a write strobe wins over a simultaneous read strobe
  assign w_wr0  = ~m0.wr_n;
  assign w_rd0  = ~m0.rd_n & m0.wr_n;
  assign w_req0 = w_wr0 | ~m0.rd_n;
  assign w_wr1  = ~m1.wr_n;
  assign w_rd1  = ~m1.rd_n & m1.wr_n;
  assign w_req1 = w_wr1 | ~m1.rd_n;

  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);

  always_comb begin
    w_sel = r_arb_sel;
    if (r_lock)
      w_sel = r_arb_sel;
    else if (w_req1 && (!w_req0 || r_starve == C_STARVE))
      w_sel = 1'b1;
    else if (w_req0)
      w_sel = 1'b0;
  end

  always_comb begin
    az.addr  = m0.addr;
    az.be_n  = m0.be_n;
    az.wdata = m0.wdata;
    w_req_s  = w_req0;
    w_rd_s   = w_rd0;
    w_wr_s   = w_wr0;
    if (w_sel) begin
      az.addr  = m1.addr;
      az.be_n  = m1.be_n;
      az.wdata = m1.wdata;
      w_req_s  = w_req1;
      w_rd_s   = w_rd1;
      w_wr_s   = w_wr1;
    end
  end

  // reads are held back from the controller while every tag slot is in use
  assign w_present_rd = reset_n & w_req_s & w_rd_s & ~w_full;
  assign w_present_wr = reset_n & w_req_s & w_wr_s;
  assign az.rd_n      = ~w_present_rd;
  assign az.wr_n      = ~w_present_wr;

  assign w_grant_ok     = reset_n & w_req_s & ~az.waitrequest & ~(w_rd_s & w_full);
  assign m0.waitrequest = ~(w_grant_ok & ~w_sel);
  assign m1.waitrequest = ~(w_grant_ok & w_sel);

  assign w_accept   = (w_present_rd | w_present_wr) & ~az.waitrequest;
  assign w_push     = w_present_rd & ~az.waitrequest;
  assign w_pop      = az.valid & ~w_empty;
  assign w_head_tag = r_tags[r_head];

  assign m0.rdata = az.rdata;
  assign m1.rdata = az.rdata;
  assign m0.valid = reset_n & w_pop & ~w_head_tag;
  assign m1.valid = reset_n & w_pop & w_head_tag;

  assign arb_sel   = r_arb_sel;
  assign tag_count = r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arb_sel       <= 1'b0;
      r_lock          <= 1'b0;
      r_starve        <= '0;
      r_count         <= '0;
      r_head          <= '0;
      r_tail          <= '0;
      r_tags          <= '0;
      err_unexp_valid <= 1'b0;
    end else begin
      r_arb_sel <= w_sel;
      // keep the grant pinned to a port whose command is stalled by the controller
      r_lock    <= (w_present_rd | w_present_wr) & az.waitrequest;

      if (!w_req1 || (w_accept && w_sel))
        r_starve <= '0;
      else if (w_accept && !w_sel && r_starve != C_STARVE)
        r_starve <= r_starve + 8'd1;

      if (w_push) begin
        r_tags[r_tail] <= w_sel;
        r_tail         <= r_tail + PW'(1);
      end
      if (w_pop)
        r_head <= r_head + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);

      if (az.valid && w_empty)
        err_unexp_valid <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sdram_port_arbiter : directed self-checking bench for sdram_port_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sdram_port_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       arb_sel;
  logic [2:0] tag_count;
  logic       err_unexp_valid;
  int         total = 0;
  int         bad   = 0;

  sdram_port_arbiter_if #(.ADDR_W(22), .DATA_W(16)) m0_if ();
  sdram_port_arbiter_if #(.ADDR_W(22), .DATA_W(16)) m1_if ();
  sdram_port_arbiter_if #(.ADDR_W(22), .DATA_W(16)) az_if ();

  sdram_port_arbiter #(
    .ADDR_W(22), .DATA_W(16), .TAG_DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .m0              (m0_if),
    .m1              (m1_if),
    .az              (az_if),
    .arb_sel         (arb_sel),
    .tag_count       (tag_count),
    .err_unexp_valid (err_unexp_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    m0_if.addr = '0; m0_if.be_n = 2'b00; m0_if.wdata = '0; m0_if.rd_n = 1'b0; m0_if.wr_n = 1'b1;
    m1_if.addr = '0; m1_if.be_n = 2'b00; m1_if.wdata = '0; m1_if.rd_n = 1'b1; m1_if.wr_n = 1'b1;
    az_if.waitrequest = 1'b0; az_if.rdata = '0; az_if.valid = 1'b1;

    // reset: outputs forced regardless of requests and controller returns
    tick(); tick();
    #2;
    check("rst_az_rd_n", az_if.rd_n, 1);
    check("rst_m0_wait", m0_if.waitrequest, 1);
    check("rst_m0_valid", m0_if.valid, 0);
    check("rst_m1_valid", m1_if.valid, 0);
    check("rst_tag_count", tag_count, 0);
    check("rst_arb_sel", arb_sel, 0);
    check("rst_err", err_unexp_valid, 0);
    tick();
    m0_if.rd_n = 1'b1; az_if.valid = 1'b0; reset_n = 1'b1;
    tick();

    // single port-0 read
    m0_if.rd_n = 1'b0; m0_if.addr = 22'h000123;
    #2;
    check("t1_az_rd_n", az_if.rd_n, 0);
    check("t1_az_addr", az_if.addr, 22'h000123);
    check("t1_m0_wait", m0_if.waitrequest, 0);
    tick();
    m0_if.rd_n = 1'b1;
    #2;
    check("t1_az_rd_n_idle", az_if.rd_n, 1);
    check("t1_count1", tag_count, 1);
    tick(); tick();
    az_if.valid = 1'b1; az_if.rdata = 16'hBEEF;
    #2;
    check("t1_m0_valid", m0_if.valid, 1);
    check("t1_m0_rdata", m0_if.rdata, 16'hBEEF);
    check("t1_m1_valid", m1_if.valid, 0);
    tick();
    az_if.valid = 1'b0;
    check("t1_count0", tag_count, 0);

    // both ports reading continuously: 8x port 0 then 1x port 1
    m0_if.rd_n = 1'b0; m1_if.rd_n = 1'b0;
    m0_if.addr = 22'h000010; m1_if.addr = 22'h200020;
    for (int k = 0; k < 18; k++) begin
      #2;
      check("t2_m1_wait", m1_if.waitrequest, (k % 9 == 8) ? 1'b0 : 1'b1);
      check("t2_m0_wait", m0_if.waitrequest, (k % 9 == 8) ? 1'b1 : 1'b0);
      tick();
      if (k == 0) az_if.valid = 1'b1;
    end
    m0_if.rd_n = 1'b1; m1_if.rd_n = 1'b1;
    tick();
    az_if.valid = 1'b0;
    check("t2_count0", tag_count, 0);
    check("t2_arb_sel", arb_sel, 1);

    // port-1 write stalled 5 clks; port 0 arrives mid-stall and must wait
    m1_if.wr_n = 1'b0; m1_if.addr = 22'h1AAAAA; m1_if.wdata = 16'h5555;
    az_if.waitrequest = 1'b1;
    #2;
    check("t3_az_wr_n", az_if.wr_n, 0);
    check("t3_az_addr_c1", az_if.addr, 22'h1AAAAA);
    check("t3_m1_wait_c1", m1_if.waitrequest, 1);
    tick();
    m0_if.rd_n = 1'b0; m0_if.addr = 22'h000777;
    for (int c = 2; c <= 5; c++) begin
      #2;
      check("t3_az_addr_hold", az_if.addr, 22'h1AAAAA);
      check("t3_az_data_hold", az_if.wdata, 16'h5555);
      check("t3_arb_sel_hold", arb_sel, 1);
      check("t3_m0_wait_hold", m0_if.waitrequest, 1);
      tick();
    end
    az_if.waitrequest = 1'b0;
    #2;
    check("t3_m1_wait_c6", m1_if.waitrequest, 0);
    check("t3_az_addr_c6", az_if.addr, 22'h1AAAAA);
    tick();
    m1_if.wr_n = 1'b1;
    #2;
    check("t3_m0_wait_c7", m0_if.waitrequest, 0);
    check("t3_az_addr_c7", az_if.addr, 22'h000777);
    check("t3_az_rd_n_c7", az_if.rd_n, 0);
    tick();
    m0_if.rd_n = 1'b1;
    check("t3_arb_sel_c7", arb_sel, 0);
    check("t3_count1", tag_count, 1);
    az_if.valid = 1'b1; az_if.rdata = 16'hCAFE;
    #2;
    check("t3_m0_valid", m0_if.valid, 1);
    check("t3_m0_rdata", m0_if.rdata, 16'hCAFE);
    tick();
    az_if.valid = 1'b0;

    // fill the tag FIFO with 0,1,0,1
    m0_if.rd_n = 1'b0; tick();
    m0_if.rd_n = 1'b1; m1_if.rd_n = 1'b0; tick();
    m0_if.rd_n = 1'b0; m1_if.rd_n = 1'b1; tick();
    m0_if.rd_n = 1'b1; m1_if.rd_n = 1'b0; tick();
    m1_if.rd_n = 1'b1; m0_if.rd_n = 1'b0;
    #2;
    check("t4_count4", tag_count, 4);
    check("t4_full_az_rd_n", az_if.rd_n, 1);
    check("t4_full_m0_wait", m0_if.waitrequest, 1);
    tick();
    m0_if.rd_n = 1'b1; m0_if.wr_n = 1'b0; m0_if.addr = 22'h000055;
    #2;
    check("t4_wr_az_wr_n", az_if.wr_n, 0);
    check("t4_wr_m0_wait", m0_if.waitrequest, 0);
    tick();
    check("t4_wr_count4", tag_count, 4);
    m0_if.wr_n = 1'b1; m0_if.rd_n = 1'b0;
    az_if.valid = 1'b1; az_if.rdata = 16'h1111;
    #2;
    check("t4_ret1_m0_valid", m0_if.valid, 1);
    check("t4_ret1_m1_valid", m1_if.valid, 0);
    check("t4_pop_az_rd_n", az_if.rd_n, 1);
    check("t4_pop_m0_wait", m0_if.waitrequest, 1);
    tick();
    az_if.rdata = 16'h2222;
    #2;
    check("t4_ret2_m1_valid", m1_if.valid, 1);
    check("t4_ret2_m0_valid", m0_if.valid, 0);
    check("t4_5th_az_rd_n", az_if.rd_n, 0);
    check("t4_5th_m0_wait", m0_if.waitrequest, 0);
    tick();
    check("t4_count3", tag_count, 3);
    m0_if.rd_n = 1'b1; az_if.rdata = 16'h3333;
    #2;
    check("t4_ret3_m0_valid", m0_if.valid, 1);
    tick();
    check("t4_count2", tag_count, 2);

    // simultaneous push and pop at count 2, head pointer wraps
    m1_if.rd_n = 1'b0; az_if.rdata = 16'h4444;
    #2;
    check("t5_ret4_m1_valid", m1_if.valid, 1);
    check("t5_m1_wait", m1_if.waitrequest, 0);
    tick();
    check("t5_count2", tag_count, 2);
    m1_if.rd_n = 1'b1; az_if.rdata = 16'h5555;
    #2;
    check("t5_ret5_m0_valid", m0_if.valid, 1);
    check("t5_ret5_m1_valid", m1_if.valid, 0);
    tick();
    az_if.rdata = 16'h6666;
    #2;
    check("t5_ret6_m1_valid", m1_if.valid, 1);
    check("t5_ret6_rdata", m1_if.rdata, 16'h6666);
    tick();
    az_if.valid = 1'b0;
    check("t5_count0", tag_count, 0);
    check("t5_err_clear", err_unexp_valid, 0);

    // reset with 3 reads outstanding, then a late return
    m0_if.rd_n = 1'b0; tick(); tick(); tick();
    m0_if.rd_n = 1'b1;
    check("t6_count3", tag_count, 3);
    reset_n = 1'b0;
    #2;
    check("t6_async_count", tag_count, 0);
    check("t6_rst_m0_wait", m0_if.waitrequest, 1);
    tick(); tick();
    reset_n = 1'b1;
    az_if.valid = 1'b1;
    #2;
    check("t6_late_m0_valid", m0_if.valid, 0);
    check("t6_late_m1_valid", m1_if.valid, 0);
    check("t6_err_before", err_unexp_valid, 0);
    tick();
    az_if.valid = 1'b0;
    check("t6_err_set", err_unexp_valid, 1);
    check("t6_count0", tag_count, 0);
    tick();
    check("t6_err_sticky", err_unexp_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
